// File: rtl/fp_pkg.sv
// Shared single-precision field layout, format constants and divider state encoding.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam int SIGN   = 31;
    localparam int EXP_HI = 30;
    localparam int EXP_LO = 23;
    localparam int MAN_HI = 22;
    localparam int MAN_LO = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

    function automatic logic [31:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction
endpackage

// File: rtl/fp_div_if.sv
// Operand/result valid-ready bundle between the divider and its producer/consumer.
interface fp_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        div_by_zero;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, y, div_by_zero);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, y, div_by_zero);
endinterface

// File: rtl/fp_mant_divider.sv
// One restoring division step: subtract the divisor when it fits, emit the quotient bit, shift.
module fp_mant_divider
    import fp_pkg::*;
(
    input  logic [MAN_W+1:0] rem,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+1:0] next_rem,
    output logic             q_bit
);
    logic [MAN_W+1:0] diff;

    always_comb begin
        q_bit    = (rem >= {1'b0, mb});
        diff     = q_bit ? (rem - {1'b0, mb}) : rem;
        next_rem = diff << 1;
    end
endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider; 28 cycles accept-to-valid for normal operands, 1 for zeros.
// One operation in flight: in_ready is low until the result has been taken by the consumer.
module fp_div
    import fp_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    fp_div_if.slave bus
);
    state_t               state;
    logic [4:0]           cnt;
    logic [MAN_W+1:0]     rem;
    logic [MAN_W:0]       mb;
    logic [MAN_W+1:0]     q;
    logic signed [9:0]    e;
    logic                 sgn;

    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [31:0]          y_r;
    logic                 dbz_r;

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.y           = y_r;
    assign bus.div_by_zero = dbz_r;

    // Operand decode and setup for the accept cycle
    fp32_t             fa, fb;
    logic              a_zero, b_zero, s_c, shift;
    logic [MAN_W:0]    ma_c, mb_c;
    logic signed [9:0] e_c;

    always_comb begin
        fa     = bus.a;
        fb     = bus.b;
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);
        s_c    = fa.sign ^ fb.sign;
        ma_c   = {1'b1, fa.man};
        mb_c   = {1'b1, fb.man};
        shift  = (ma_c < mb_c);
        e_c    = {2'b00, fa.exp} - {2'b00, fb.exp} + 10'(BIAS) - {9'd0, shift};
    end

    logic [MAN_W+1:0] next_rem;
    logic             q_bit;

    fp_mant_divider u_step (
        .rem      (rem),
        .mb       (mb),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    // The integer quotient bit is always 1 and falls off the top of q; q[1]=G, q[0]=R.
    logic [MAN_W-1:0]  frac, man_r;
    logic              sticky, inc, carry;
    logic signed [9:0] e_r;
    logic [31:0]       res;

    always_comb begin
        frac   = q[MAN_W+1:2];
        sticky = |rem;
        inc    = q[1] & (q[0] | sticky | q[2]);
        carry  = inc & (&frac);
        man_r  = frac + MAN_W'(inc);
        e_r    = e + {9'd0, carry};
        if (e_r >= $signed(10'd255))
            res = fp_pack(sgn, '1, '0);
        else if (e_r <= $signed(10'd0))
            res = fp_pack(sgn, '0, '0);
        else
            res = fp_pack(sgn, e_r[EXP_W-1:0], man_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            mb          <= '0;
            q           <= '0;
            e           <= '0;
            sgn         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            y_r         <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        sgn        <= s_c;
                        dbz_r      <= b_zero;
                        if (a_zero || b_zero) begin
                            y_r         <= b_zero ? fp_pack(s_c, '1, '0) : fp_pack(s_c, '0, '0);
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            mb    <= mb_c;
                            rem   <= shift ? {ma_c, 1'b0} : {1'b0, ma_c};
                            e     <= e_c;
                            q     <= '0;
                            cnt   <= 5'd25;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= next_rem;
                    q   <= {q[MAN_W:0], q_bit};
                    if (cnt == 5'd0)
                        state <= RND;
                    else
                        cnt <= cnt - 5'd1;
                end
                RND: begin
                    y_r         <= res;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
